// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if: client handshake plus SPI bus of the two-client SPI master
interface spi_master_arb_if;
  logic [1:0] req;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] ack;
  logic [1:0] done;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  modport master (input req, tx_data0, tx_data1, miso,
                  output ack, done, rx_data, busy, sclk, cs, mosi);
  modport slave  (output req, tx_data0, tx_data1, miso,
                  input ack, done, rx_data, busy, sclk, cs, mosi);
endinterface

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin two-client SPI mode-0 master, one MSB-first byte per grant
module spi_master_arb #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input logic              clk,
  input logic              rst_n,
  spi_master_arb_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3;
  localparam int CW = $clog2(CLK_DIV + CS_GAP + 1) + 1;
  logic [1:0]    state_q, state_d, ack_q, done_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    tog_q;
  logic [7:0]    tx_q, rx_q, rx_data_q, txw;
  logic          ptr_q, win_q, busy_q, sclk_q, cs_q, mosi_q;
  logic          win, grant, tick, fin, gap_end;
  always_comb begin
    win     = (&bus.req) ? ptr_q : bus.req[1];
    txw     = win ? bus.tx_data1 : bus.tx_data0;
    grant   = state_q == IDLE && |bus.req;
    tick    = (state_q == SETUP || state_q == SHIFT) && cnt_q == CW'(CLK_DIV - 1);
    fin     = tick && tog_q == 5'd16;
    gap_end = state_q == GAP && cnt_q == CW'(CS_GAP - 1);
    state_d = grant ? SETUP :
              (state_q == SETUP && tick) ? SHIFT :
              fin ? ((CS_GAP == 0) ? IDLE : GAP) :
              gap_end ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d != IDLE;
      cnt_q   <= (state_d != state_q || tick) ? '0 : cnt_q + 1'b1;
      ack_q   <= '0;
      done_q  <= '0;
      if (grant) begin
        tx_q       <= {txw[6:0], 1'b0};
        mosi_q     <= txw[7];
        cs_q       <= 1'b0;
        ack_q[win] <= 1'b1;
        win_q      <= win;
        ptr_q      <= ~win;
        tog_q      <= '0;
      end
      // rising SCLK captures miso; falling SCLK advances mosi (zero after bit 0)
      if (tick && !fin) begin
        sclk_q <= ~sclk_q;
        tog_q  <= tog_q + 5'd1;
        if (!sclk_q) rx_q <= {rx_q[6:0], bus.miso};
        else begin
          mosi_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end
      end
      if (fin) begin
        cs_q          <= 1'b1;
        rx_data_q     <= rx_q;
        done_q[win_q] <= 1'b1;
      end
    end
  end
  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.sclk    = sclk_q;
  assign bus.cs      = cs_q;
  assign bus.mosi    = mosi_q;
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: randomized scenario bench for spi_master_arb at two divider settings
module tb_spi_master_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_master_arb_if i4 ();
  spi_master_arb_if i1 ();
  spi_master_arb #(.CLK_DIV(4), .CS_GAP(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  spi_master_arb #(.CLK_DIV(1), .CS_GAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  int errors = 0, checks = 0;
  logic lb4 = 1'b1;
  logic [7:0] pat = 8'h00;
  logic mptr [2] = '{1'b0, 1'b0};
  // bus observers: cs run lengths, sclk edges, mosi at rises, pulse counts, slave shifter
  int low_len [2], cur_low [2], high_len [2], cur_high [2], rises [2], togs [2];
  int d0 [2], d1 [2], a1 [2], ovl [2];
  logic [7:0] mcap [2], sl [2];
  bit pcs [2] = '{1'b1, 1'b1};
  bit psc [2] = '{1'b0, 1'b0};
  assign i4.miso = lb4 ? i4.mosi : sl[0][7];
  assign i1.miso = i1.mosi;
  initial begin
    i4.req = 2'b00; i4.tx_data0 = 8'h00; i4.tx_data1 = 8'h00;
    i1.req = 2'b00; i1.tx_data0 = 8'h00; i1.tx_data1 = 8'h00;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic c, s, m;
      logic [1:0] a, dn;
      c  = k ? i1.cs : i4.cs;
      s  = k ? i1.sclk : i4.sclk;
      m  = k ? i1.mosi : i4.mosi;
      a  = k ? i1.ack : i4.ack;
      dn = k ? i1.done : i4.done;
      if (!c) begin
        if (pcs[k]) begin high_len[k] = cur_high[k]; cur_low[k] = 0; rises[k] = 0; togs[k] = 0; end
        cur_low[k]++;
      end else begin
        if (!pcs[k]) begin low_len[k] = cur_low[k]; cur_high[k] = 0; end
        cur_high[k]++;
      end
      if (s != psc[k]) togs[k]++;
      if (s && !psc[k]) begin rises[k]++; mcap[k] = {mcap[k][6:0], m}; end
      if (c) sl[k] = pat;
      else if (!s && psc[k]) sl[k] = {sl[k][6:0], 1'b0};
      if (a[1]) a1[k]++;
      if (dn[0]) d0[k]++;
      if (dn[1]) d1[k]++;
      if (|a && |dn) ovl[k]++;
      pcs[k] = c;
      psc[k] = s;
    end
  end
  task automatic tick();
    @(negedge clk); #1;
  endtask
  task automatic wait_idle(input int k);
    int n = 0;
    while ((k ? i1.busy : i4.busy) && n < 100) begin tick(); n++; end
    if (n >= 100) begin checks++; errors++; $display("FAIL idle_timeout dut%0d busy stuck after %0d cycles, want idle", k, n); end
  endtask
  task automatic wait_ack(input int k, output logic [1:0] a, output int n);
    n = 0; a = 2'b00;
    while (a == 2'b00 && n < 40) begin tick(); n++; a = k ? i1.ack : i4.ack; end
    if (a == 2'b00) begin checks++; errors++; $display("FAIL ack_timeout dut%0d no ack in %0d cycles", k, n); end
  endtask
  task automatic wait_done(input int k, output logic [1:0] dn, output logic [7:0] rx);
    int n = 0;
    dn = 2'b00;
    while (dn == 2'b00 && n < 300) begin tick(); n++; dn = k ? i1.done : i4.done; end
    rx = k ? i1.rx_data : i4.rx_data;
    if (dn == 2'b00) begin checks++; errors++; $display("FAIL done_timeout dut%0d no done in %0d cycles", k, n); end
  endtask
  task automatic xfer(input int k, input int c, input logic [7:0] d, input logic [7:0] exp);
    logic [1:0] a, dn;
    logic [7:0] rx;
    int n, div;
    div = k ? 1 : 4;
    wait_idle(k);
    if (k == 0) begin if (c != 0) i4.tx_data1 = d; else i4.tx_data0 = d; i4.req[c] = 1'b1; end
    else begin if (c != 0) i1.tx_data1 = d; else i1.tx_data0 = d; i1.req[c] = 1'b1; end
    wait_ack(k, a, n);
    if (k == 0) i4.req[c] = 1'b0; else i1.req[c] = 1'b0;
    mptr[k] = (c == 0);
    checks++; if (n !== 1) begin errors++; $display("FAIL ack_latency dut%0d got %0d want 1", k, n); end
    checks++; if (a !== 2'(1 << c)) begin errors++; $display("FAIL ack_client dut%0d got %b want %b", k, a, 2'(1 << c)); end
    wait_done(k, dn, rx);
    tick();
    checks++; if (dn !== 2'(1 << c)) begin errors++; $display("FAIL done_client dut%0d got %b want %b", k, dn, 2'(1 << c)); end
    checks++; if (rx !== exp) begin errors++; $display("FAIL rx_data dut%0d got %h want %h", k, rx, exp); end
    checks++; if (low_len[k] !== 17 * div) begin errors++; $display("FAIL cs_low dut%0d got %0d want %0d", k, low_len[k], 17 * div); end
    checks++; if (rises[k] !== 8) begin errors++; $display("FAIL sclk_rises dut%0d got %0d want 8", k, rises[k]); end
    checks++; if (mcap[k] !== d) begin errors++; $display("FAIL mosi_bits dut%0d got %h want %h", k, mcap[k], d); end
  endtask
  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({i4.cs, i4.sclk, i4.mosi, i4.busy, i4.ack, i4.done, i4.rx_data} !== {4'b1000, 12'h000}) begin
      errors++; $display("FAIL reset_dut0 got cs=%b sclk=%b mosi=%b busy=%b ack=%b done=%b rx=%h", i4.cs, i4.sclk, i4.mosi, i4.busy, i4.ack, i4.done, i4.rx_data);
    end
    checks++;
    if ({i1.cs, i1.sclk, i1.mosi, i1.busy, i1.ack, i1.done, i1.rx_data} !== {4'b1000, 12'h000}) begin
      errors++; $display("FAIL reset_dut1 got cs=%b sclk=%b mosi=%b busy=%b ack=%b done=%b rx=%h", i1.cs, i1.sclk, i1.mosi, i1.busy, i1.ack, i1.done, i1.rx_data);
    end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_loopback();
    int d1s;
    lb4 = 1'b1;
    d1s = d1[0];
    xfer(0, 0, 8'hA5, 8'hA5);
    checks++; if (d1[0] !== d1s) begin errors++; $display("FAIL done1_spurious got %0d pulses want 0", d1[0] - d1s); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      int c;
      d = 8'($urandom);
      c = int'($urandom_range(0, 1));
      xfer(0, c, d, d);
    end
  endtask
  task automatic test_pattern();
    logic [7:0] d, p;
    lb4 = 1'b0;
    pat = 8'h3C;
    xfer(0, 1, 8'h7F, 8'h3C);
    d = 8'($urandom); p = 8'($urandom);
    pat = p;
    xfer(0, 1, d, p);
    lb4 = 1'b1;
  endtask
  task automatic test_round_robin();
    logic [1:0] a, dn;
    logic [7:0] rx;
    int n, w;
    i4.tx_data0 = 8'h00; i4.tx_data1 = 8'hFF;
    i4.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = int'(mptr[0]);
      wait_ack(0, a, n);
      mptr[0] = (w == 0);
      checks++; if (a !== 2'(1 << w)) begin errors++; $display("FAIL rr_grant #%0d got %b want %b", i, a, 2'(1 << w)); end
      wait_done(0, dn, rx);
      if (i == 3) i4.req = 2'b00;
      checks++; if (rx !== (w != 0 ? 8'hFF : 8'h00)) begin errors++; $display("FAIL rr_rx #%0d got %h want %h", i, rx, (w != 0 ? 8'hFF : 8'h00)); end
      if (i > 0) begin
        checks++; if (high_len[0] !== 5) begin errors++; $display("FAIL rr_cs_gap #%0d got %0d want 5", i, high_len[0]); end
      end
    end
  endtask
  task automatic test_withdraw();
    int a1s;
    xfer(0, 0, 8'($urandom), 8'h00 | 8'h00);
  endtask
  task automatic test_withdraw_gap();
    int a1s;
    logic [7:0] d;
    d = 8'($urandom);
    xfer(0, 0, d, d);
    a1s = a1[0];
    i4.req[1] = 1'b1; i4.tx_data1 = 8'h11;
    tick(); tick();
    i4.req[1] = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++; if (a1[0] !== a1s) begin errors++; $display("FAIL withdraw_ack1 got %0d acks want 0", a1[0] - a1s); end
    checks++; if ({i4.cs, i4.busy} !== 2'b10) begin errors++; $display("FAIL withdraw_idle got cs=%b busy=%b want cs=1 busy=0", i4.cs, i4.busy); end
  endtask
  task automatic test_reset_mid();
    logic [1:0] a, dn;
    logic [7:0] rx, d;
    int n, d0s;
    d = 8'($urandom);
    wait_idle(0);
    i4.tx_data0 = d; i4.req[0] = 1'b1;
    n = 0;
    while (rises[0] < 3 && n < 100) begin tick(); n++; end
    checks++; if (rises[0] < 3) begin errors++; $display("FAIL mid_rises got %0d want 3", rises[0]); end
    d0s = d0[0];
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i4.cs, i4.sclk, i4.mosi, i4.busy} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_async got cs=%b sclk=%b mosi=%b busy=%b want 1000", i4.cs, i4.sclk, i4.mosi, i4.busy);
    end
    tick(); tick(); tick();
    checks++; if (d0[0] !== d0s || i4.rx_data !== 8'h00) begin errors++; $display("FAIL mid_no_done got %0d done rx=%h want 0 done rx=00", d0[0] - d0s, i4.rx_data); end
    mptr[0] = 1'b0;
    mptr[1] = 1'b0;
    rst_n = 1'b1;
    wait_ack(0, a, n);
    i4.req[0] = 1'b0;
    mptr[0] = 1'b1;
    checks++; if (a !== 2'b01 || n !== 1) begin errors++; $display("FAIL mid_reack got ack=%b lat=%0d want 01 lat=1", a, n); end
    wait_done(0, dn, rx);
    checks++; if (dn !== 2'b01 || rx !== d) begin errors++; $display("FAIL mid_redo got done=%b rx=%h want 01 %h", dn, rx, d); end
  endtask
  task automatic test_min_div();
    logic [7:0] d;
    xfer(1, 0, 8'h5A, 8'h5A);
    checks++; if (togs[1] !== 16) begin errors++; $display("FAIL min_div_toggles got %0d want 16", togs[1]); end
    d = 8'($urandom);
    xfer(1, 1, d, d);
    checks++; if (togs[1] !== 16) begin errors++; $display("FAIL min_div_toggles2 got %0d want 16", togs[1]); end
  endtask
  initial begin
    test_reset();
    test_loopback();
    test_pattern();
    test_round_robin();
    test_withdraw_gap();
    test_reset_mid();
    test_min_div();
    checks++; if (ovl[0] + ovl[1] !== 0) begin errors++; $display("FAIL ack_done_overlap got %0d cycles want 0", ovl[0] + ovl[1]); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

Two-requester SPI mode-0 master that shares one SPI bus (`sclk`, `cs`, `mosi`, `miso`) between two on-chip clients. It arbitrates round-robin, frames each request as one 8-bit MSB-first transaction, and returns the byte captured on `miso` to the granted client. It sits between system logic and the 8-bit SPI echo slave, sequencing chip-select, SCLK generation and inter-byte gaps.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; legal range is 1 or more.
- `CS_GAP`, 4: extra `clk` cycles `cs` stays high after a transaction; legal range is 0 or more.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 2: per-client request; client i holds `req[i]` high until `ack[i]`.
- `tx_data0` in 8: client 0 transmit byte; must be stable while `req[0]` is high.
- `tx_data1` in 8: client 1 transmit byte; must be stable while `req[1]` is high.
- `ack` out 2: one-cycle pulse when the client's request is accepted and its `tx_data` is captured.
- `done` out 2: one-cycle pulse to the served client; `rx_data` is valid in that cycle.
- `rx_data` out 8: received byte; holds its value until the next `done`.
- `busy` out 1: high whenever state is not IDLE.
- `sclk` out 1: SPI clock; idles low.
- `cs` out 1: SPI chip-select, active-low.
- `mosi` out 1: serial data to slave.
- `miso` in 1: serial data from slave; treated as synchronous to the SCLK the block generates.

## Operation
- **States:** IDLE → SETUP → SHIFT → GAP → IDLE.
- **IDLE**
  - If any `req` bit is high, pick a winner; at the next edge go to SETUP.
  - With one request, that client wins.
  - With two requests, the client not served last wins.
  - The last-served pointer resets so that client 0 wins the first tie.
- **Entry to SETUP** (same edge)
  - Latch the winner's `tx_data` into the shift register.
  - `cs` goes 0, `mosi` takes bit 7, `sclk` stays 0.
  - Pulse `ack[winner]`.
  - Record the winner for `done` and for the round-robin pointer.
- **SETUP:** hold for `CLK_DIV` cycles, then go to SHIFT.
- **SHIFT:** toggle `sclk` every `CLK_DIV` cycles, for 16 toggles in total (8 rising, 8 falling).
  - On the edge that drives `sclk` 0→1: sample `miso` into the receive shift register, MSB first.
  - On the edge that drives `sclk` 1→0, after bits 7..1: `mosi` takes the next lower bit.
  - On the falling edge after bit 0: `mosi` goes 0.
  - After the 16th toggle, `sclk` has stayed low for `CLK_DIV` cycles. At the next edge:
    - `cs` goes 1;
    - `rx_data` takes the received byte;
    - `done[winner]` pulses;
    - state goes to GAP.
- **GAP:** hold `cs` high for `CS_GAP` cycles, then go to IDLE. Requests are ignored during SETUP, SHIFT and GAP.
- **Request withdrawal:** a request dropped before arbitration is never granted. Dropping `req` after `ack` has no effect.
- **Reset, including mid-transaction:**
  - The transaction is aborted with no `done`.
  - Outputs: `cs`=1, `sclk`=0, `mosi`=0, `ack`=0, `done`=0, `rx_data`=0, `busy`=0.
  - State goes to IDLE and the pointer is cleared.
- **Counters:** the half-period counter is wide enough for `CLK_DIV`, and the toggle counter is 5 bits (0..16).

## Timing
- All outputs are registered.
- The `ack` cycle is the first cycle with `cs`=0.
- `cs` stays low for exactly 17·`CLK_DIV` cycles: `CLK_DIV` of setup, then 16 half-periods.
- The first `sclk` rise is `CLK_DIV` cycles after `cs` falls.
- `done` is asserted in the first cycle with `cs`=1.
- Between transactions, `cs` stays high for at least `CS_GAP`+1 cycles: `CS_GAP` in GAP plus 1 arbitration cycle.
- Minimum `req`-to-`ack` latency from IDLE is 1 cycle.
- Back-to-back throughput is 17·`CLK_DIV` + `CS_GAP` + 1 cycles per byte.
- `ack` and `done` never overlap for the same transaction.
- `ack` and `done` are never both high in the same cycle.

## Test plan
- **Loopback**
  - Stimulus: `miso` tied to `mosi`, `CLK_DIV`=4, `CS_GAP`=4; `req[0]` with `tx_data0`=0xA5.
  - Response: `ack[0]` one cycle after `req`; `cs` low for 68 cycles; 8 `sclk` rises; `done[0]` with `rx_data`=0xA5; `done[1]` never pulses.
- **Fixed slave pattern**
  - Stimulus: bench model shifts 0x3C on `miso`, changing on `sclk` falls; client 1 sends 0x7F.
  - Response: bits captured on `mosi` at `sclk` rises equal 0x7F; `rx_data`=0x3C at `done[1]`.
- **Simultaneous requests, round-robin**
  - Stimulus: both `req` held continuously, `tx_data0`=0x00, `tx_data1`=0xFF; run 4 transactions in loopback.
  - Response: grant order 0,1,0,1; `rx_data` sequence 0x00, 0xFF, 0x00, 0xFF.
  - Response: each `cs` high gap is exactly 5 cycles.
- **Reset mid-transaction**
  - Stimulus: assert `rst_n`=0 after the 3rd `sclk` rise.
  - Response: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0 immediately without a clock; no `done`.
  - Response: after release with `req[0]` high, a full normal transaction completes and `rx_data` is correct.
- **Minimum divider and request withdrawal**
  - Stimulus: `CLK_DIV`=1, `CS_GAP`=0, loopback 0x5A.
  - Response: `cs` low for 17 cycles; `sclk` alternates every cycle; `rx_data`=0x5A.
  - Stimulus: during GAP, pulse `req[1]` and drop it before IDLE.
  - Response: no `ack[1]`.
